// File: rtl/rr_grant_arbiter.sv
// rtl/rr_grant_arbiter.sv - four-requester round-robin arbiter with registered one-hot grant and hold limit
module rr_grant_arbiter #(
  parameter int MAX_HOLD = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [3:0] grant,
  output logic       busy,
  output logic       timeout
);

  generate
    if (MAX_HOLD < 0 || MAX_HOLD > 255) begin : g_bad_max_hold
      $error("rr_grant_arbiter: MAX_HOLD must be in 0..255");
    end
  endgenerate

  localparam logic [7:0] LP_MAX_HOLD = 8'(MAX_HOLD);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t     r_state, w_state_nxt;
  logic [1:0] r_ptr, w_ptr_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [7:0] r_hcnt, w_hcnt_nxt;
  logic [3:0] r_grant, w_grant_nxt;
  logic       r_timeout, w_timeout_nxt;

  logic [7:0] w_req_dbl;
  logic [3:0] w_req_rot;
  logic [1:0] w_offset;
  logic [1:0] w_winner;
  logic       w_found;
  logic       w_at_limit;

  // Rotate req so the pointer position lands in bit 0, then take the lowest set bit.
  assign w_req_dbl = {req, req} >> r_ptr;
  assign w_req_rot = w_req_dbl[3:0];

  always_comb begin
    w_found  = 1'b0;
    w_offset = 2'd0;
    if (w_req_rot[0]) begin
      w_found  = 1'b1;
      w_offset = 2'd0;
    end else if (w_req_rot[1]) begin
      w_found  = 1'b1;
      w_offset = 2'd1;
    end else if (w_req_rot[2]) begin
      w_found  = 1'b1;
      w_offset = 2'd2;
    end else if (w_req_rot[3]) begin
      w_found  = 1'b1;
      w_offset = 2'd3;
    end
  end

  assign w_winner   = r_ptr + w_offset;
  assign w_at_limit = (LP_MAX_HOLD != 8'd0) && (r_hcnt == LP_MAX_HOLD);

  always_comb begin
    w_state_nxt   = r_state;
    w_ptr_nxt     = r_ptr;
    w_owner_nxt   = r_owner;
    w_hcnt_nxt    = r_hcnt;
    w_grant_nxt   = r_grant;
    w_timeout_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_grant_nxt = 4'b0000;
        if (w_found) begin
          w_state_nxt = S_GRANT;
          w_owner_nxt = w_winner;
          w_grant_nxt = 4'b0001 << w_winner;
          w_hcnt_nxt  = 8'd1;
        end
      end
      S_GRANT: begin
        if (done || !req[r_owner] || w_at_limit) begin
          w_state_nxt   = S_IDLE;
          w_grant_nxt   = 4'b0000;
          w_ptr_nxt     = r_owner + 2'd1;
          w_hcnt_nxt    = 8'd0;
          // done and a lost request both take precedence over the hold limit
          w_timeout_nxt = !done && req[r_owner];
        end else if (r_hcnt != 8'hFF) begin
          w_hcnt_nxt = r_hcnt + 8'd1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_grant_nxt = 4'b0000;
        w_hcnt_nxt  = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_ptr     <= 2'd0;
      r_owner   <= 2'd0;
      r_hcnt    <= 8'd0;
      r_grant   <= 4'b0000;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_owner   <= w_owner_nxt;
      r_hcnt    <= w_hcnt_nxt;
      r_grant   <= w_grant_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  assign grant   = r_grant;
  assign busy    = (r_state == S_GRANT);
  assign timeout = r_timeout;

endmodule

// File: doc/rr_grant_arbiter.md
# rr_grant_arbiter

Four-requester round-robin arbiter that turns independent request lines into a registered, strictly one-hot grant vector. It sits directly upstream of the 4-to-2 encoder: `grant[3:0]` drives the encoder's one-hot input, so the encoder only ever sees all-zero or exactly one bit set. A grant is held until the owner releases it, drops its request, or exceeds a configurable hold limit.

## Interface
- `MAX_HOLD`, default 15: maximum number of consecutive cycles one grant may be held. Legal range is 0..255; 0 disables the timeout.
- `clk`  in  1  single clock for the block; all state updates on its rising edge.
- `rst_n`  in  1  synchronous, active-low reset, sampled on the rising edge of `clk`.
- `req`  in  4  request lines; bit i = requester i. Level-sensitive.
- `done`  in  1  release strobe from the current owner; sampled only in GRANT.
- `grant`  out  4  registered grant; all-zero or exactly one bit set.
- `busy`  out  1  high while in GRANT; equals |grant.
- `timeout`  out  1  one-cycle pulse when a grant is revoked by the hold limit.

## Operation
- **State**
  - 2-state FSM: IDLE, GRANT.
  - 2-bit priority pointer `ptr`.
  - 8-bit hold counter `hcnt`.
- **Reset** (rst_n=0 at an edge): state=IDLE, ptr=0, hcnt=0, grant=4'b0000, busy=0, timeout=0. This applies from any state, including mid-grant; no residual pulse follows.
- **IDLE**
  - If req==0, stay in IDLE with grant=0.
  - Otherwise, pick the first set bit of `req` searching cyclically ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  - Next edge: grant=onehot(winner), hcnt=1, state=GRANT.
- **GRANT**: the grant stays constant. Exit conditions are evaluated each edge, in priority order:
  1. done=1 → release, timeout=0.
  2. req[owner]=0 → release, timeout=0.
  3. MAX_HOLD≠0 and hcnt==MAX_HOLD → release, timeout=1 for one cycle.
  4. Otherwise stay and increment hcnt. hcnt saturates at 255; with MAX_HOLD=0 it never exits on time.
- **Release**: next edge gives grant=0, state=IDLE, ptr=(owner+1) mod 4, hcnt=0.
- **Fairness**: the most recent owner has the lowest priority next round. A requester that holds `req` continuously is granted within 3 other grants.
- **Width rules**: ptr increment wraps 3→0. hcnt compares as unsigned 8-bit. `MAX_HOLD` >255 is illegal (elaboration check).
- **Interface rules**
  - A request arriving while another grant is active waits; it is not preempted.
  - `done` asserted in IDLE is ignored.

## Timing
- **Grant latency**: req sampled at edge t → grant visible after edge t (1 cycle).
- **Release**: a release condition at edge t → grant=0 after edge t. The new arbitration happens at edge t+1, so there is at least one all-zero cycle between consecutive grants. The downstream encoder never sees two bits set or a direct bit-to-bit switch.
- **Hold length**: with MAX_HOLD=M and no release, grant is high for exactly M cycles. `timeout` is high during the first all-zero cycle after the grant.
- **Outputs**: `busy` and `timeout` are registered, aligned with `grant`.
- **Simultaneous events**: done and hold-limit on the same edge count as done; no timeout pulse.
- **Throughput**: back-to-back requesters with done after 1 cycle are granted every 2 cycles.

## Test plan
- **Reset**: hold rst_n=0 for 2 edges with req=4'b1111 → grant=0000, busy=0, timeout=0. After release, the first grant is 0001.
- **Rotation**: req=1111 held; done pulsed on every grant cycle → grant sequence 0001, 0000, 0010, 0000, 0100, 0000, 1000, 0000, 0001.
- **Skip and wrap**: ptr=3 (after a grant to req 2), req=0101 → grant=0001; then after release, grant=0100.
- **Timeout**: MAX_HOLD=4, req=0010 held, done=0 → grant=0010 for exactly 4 cycles, then 0000 with timeout=1 for 1 cycle, then 0010 again.
- **Owner drop and collision**
  - req 2 granted, then req[2] drops → grant=0000 next edge, timeout=0.
  - Separately, done=1 on the same edge as hcnt==MAX_HOLD → timeout stays 0.
- **Mid-grant reset**: grant=1000 active, rst_n=0 for 1 edge → grant=0000, ptr=0. With req=1001, the next grant is 0001.
